// File: rtl/neural_layer.sv
// Two-input, two-output fully connected layer in signed Q8.8 with identity activation.
// Each output is a saturated weighted sum of A and B, registered on every rising clk edge.
module neural_layer (
   input  logic               clk,
   input  logic               rst,
   input  logic signed [15:0] A,
   input  logic signed [15:0] B,
   input  logic signed [15:0] cAA,
   input  logic signed [15:0] cAB,
   input  logic signed [15:0] cBA,
   input  logic signed [15:0] cBB,
   output logic signed [15:0] o1,
   output logic signed [15:0] o2
);

   localparam logic signed [32:0] SAT_MAX = 33'sd32767;
   localparam logic signed [32:0] SAT_MIN = -33'sd32768;

   // Q16.16 sum back to Q8.8: arithmetic shift floors toward -inf, then clamp to 16 bits.
   function automatic logic signed [15:0] scale_sat(input logic signed [32:0] sum);
      logic signed [32:0] shifted;
      shifted = sum >>> 8;
      if (shifted > SAT_MAX)
         return 16'sh7FFF;
      else if (shifted < SAT_MIN)
         return 16'sh8000;
      else
         return shifted[15:0];
   endfunction

   logic signed [31:0] p_aa, p_ba, p_ab, p_bb;
   logic signed [32:0] s1, s2;
   logic signed [15:0] o1_next, o2_next;

   // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      p_aa    = A * cAA;
      p_ba    = B * cBA;
      p_ab    = A * cAB;
      p_bb    = B * cBB;
      s1      = $signed({p_aa[31], p_aa}) + $signed({p_ba[31], p_ba});
      s2      = $signed({p_ab[31], p_ab}) + $signed({p_bb[31], p_bb});
      o1_next = scale_sat(s1);
      o2_next = scale_sat(s2);
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         o1 <= '0;
         o2 <= '0;
      end else begin
         o1 <= o1_next;
         o2 <= o2_next;
      end
   end

endmodule

// File: tb/tb_neural_layer.sv
// Self-checking bench for neural_layer: directed corner cases, async reset, and
// randomized back-to-back stimulus against a floor-division reference model.
module tb_neural_layer;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] A, B, cAA, cAB, cBA, cBB;
   logic [15:0] o1, o2;

   int n_vec = 0;
   int n_err = 0;

   neural_layer dut (
      .clk (clk),
      .rst (rst),
      .A   (A),
      .B   (B),
      .cAA (cAA),
      .cAB (cAB),
      .cBA (cBA),
      .cBB (cBB),
      .o1  (o1),
      .o2  (o2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h want %h at %0t", tag, got, want, $time);
      end
   endtask

   // Reference neuron: exact integer sum, floor divide by 256, clamp to the 16-bit signed range.
   function automatic logic [15:0] ref_neuron(input logic [15:0] a, input logic [15:0] wa,
                                              input logic [15:0] b, input logic [15:0] wb);
      longint s;
      longint q;
      s = longint'($signed(a)) * longint'($signed(wa)) + longint'($signed(b)) * longint'($signed(wb));
      if (s >= 0) q = s / 256;
      else        q = -((-s + 255) / 256);
      if (q > 32767)  q = 32767;
      if (q < -32768) q = -32768;
      return q[15:0];
   endfunction

   task automatic drive(input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] w_aa, input logic [15:0] w_ab,
                        input logic [15:0] w_ba, input logic [15:0] w_bb);
      A = a; B = b; cAA = w_aa; cAB = w_ab; cBA = w_ba; cBB = w_bb;
   endtask

   // Apply one vector, let one edge capture it, then sample 1 time unit after that edge.
   task automatic run_case(input string tag,
                           input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] w_aa, input logic [15:0] w_ab,
                           input logic [15:0] w_ba, input logic [15:0] w_bb,
                           input logic [15:0] e1, input logic [15:0] e2, input bit chk2);
      drive(a, b, w_aa, w_ab, w_ba, w_bb);
      @(posedge clk); #1;
      check({tag, "_o1"}, o1, e1);
      if (chk2) check({tag, "_o2"}, o2, e2);
   endtask

   function automatic logic [15:0] rand_operand();
      logic [15:0] v;
      v = 16'($urandom);
      case ($urandom_range(0, 3))
         0, 1:    v = {{6{v[9]}}, v[9:0]};
         2:       v = {{8{v[7]}}, v[7:0]};
         default: ;
      endcase
      return v;
   endfunction

   initial begin
      logic [15:0] e1, e2;

      rst = 1'b1;
      drive(16'h1234, 16'hBEEF, 16'h0F0F, 16'h7777, 16'h8001, 16'h0042);
      #3;
      check("reset_o1_no_edge", o1, 16'h0000);
      check("reset_o2_no_edge", o2, 16'h0000);
      @(posedge clk); #1;
      check("reset_hold_o1", o1, 16'h0000);
      check("reset_hold_o2", o2, 16'h0000);
      rst = 1'b0;

      run_case("zero_weights", 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1);
      run_case("path_a",       16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 1'b1);
      run_case("path_b",       16'h0100, 16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 1'b1);
      run_case("all_one",      16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1'b1);
      run_case("neg_weight",   16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF, 16'h0100, 16'h0100, 16'h00FF, 16'h00FF, 1'b1);
      run_case("trunc_pos",    16'h0001, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
      run_case("trunc_neg",    16'hFFFF, 16'h0100, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0);
      run_case("sat_pos",      16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
      run_case("sat_neg",      16'h8000, 16'h0100, 16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 1'b0);
      run_case("independent",  16'h0100, 16'h0100, 16'h0200, 16'h0000, 16'h0000, 16'hFE00, 16'h0200, 16'hFE00, 1'b1);

      // Outputs now hold non-zero values; a mid-cycle reset must clear them without an edge.
      #2 rst = 1'b1;
      #1;
      check("async_rst_o1", o1, 16'h0000);
      check("async_rst_o2", o2, 16'h0000);
      #2 rst = 1'b0;
      run_case("after_rst", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0200, 16'h0200, 1'b1);

      for (int i = 0; i < 300; i++) begin
         drive(rand_operand(), rand_operand(), rand_operand(), rand_operand(), rand_operand(), rand_operand());
         e1 = ref_neuron(A, cAA, B, cBA);
         e2 = ref_neuron(A, cAB, B, cBB);
         @(posedge clk); #1;
         check("rand_o1", o1, e1);
         check("rand_o2", o2, e2);
         // New inputs after the edge must not disturb the registered outputs.
         drive(rand_operand(), rand_operand(), rand_operand(), rand_operand(), rand_operand(), rand_operand());
         #2;
         check("rand_hold_o1", o1, e1);
         check("rand_hold_o2", o2, e2);
         if (i == 150) begin
            rst = 1'b1;
            #1;
            check("rand_rst_o1", o1, 16'h0000);
            check("rand_rst_o2", o2, 16'h0000);
            @(posedge clk); #1;
            check("rand_rst_hold_o1", o1, 16'h0000);
            check("rand_rst_hold_o2", o2, 16'h0000);
            #2 rst = 1'b0;
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
